fpp_fmul_seq: RTL and testbench

//  Parametrised iterative floating-point multiplier for the FPP datapath family. Replaces the fixed
//  16-bit MUL path with a shift-add core generalised over exponent/mantissa width (IEEE-754 style

---
 rtl/fpp_fmul_seq_if.sv | 42 ++++
 rtl/fpp_fmul_seq.sv | 197 +++++++++++++++++++
 tb/tb_fpp_fmul_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fpp_fmul_seq_if.sv
// Operand/result handshake bundle for the iterative FPP multiplier.
// The master side presents operands and drains results; the slave side is the multiplier.
interface fpp_fmul_seq_if #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [2:0]   exc;
    logic         busy;

    modport master (
        output in_valid,
        output op_a,
        output op_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  exc,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  op_a,
        input  op_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output exc,
        output busy
    );
endinterface

// File: rtl/fpp_fmul_seq.sv
// Iterative shift-add floating-point multiplier with round-to-nearest-even and exception flags.
// One multiplier bit per cycle, then a single normalise/round/classify cycle.
module fpp_fmul_seq #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input logic           clk,
    input logic           rst,
    fpp_fmul_seq_if.slave bus_io
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned SW   = MAN_W + 1;
    localparam int unsigned PW   = 2 * SW;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned CW   = $clog2(SW);
    localparam int unsigned BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int unsigned MAXE = 2 ** EXP_W - 1;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [SW-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic [W-1:0]    result_q, result_d;
    logic [2:0]      exc_q, exc_d;

    logic             sa, sb, sign;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [EW-1:0]    e_raw, e_norm, e_fin;
    logic [PW-1:0]    shifted;
    logic             lost, guard, sticky, rnd_up;
    logic [MAN_W-1:0] man_t, man_f;
    logic [MAN_W:0]   man_r;
    logic             e_low, e_high;
    logic [W-1:0]     norm_res;
    logic [2:0]       norm_exc;
    logic             unused_bits;

    // Normalise, round and classify from the latched operands and finished product.
    always_comb begin
        sa     = a_q[W-1];
        sb     = b_q[W-1];
        ea     = a_q[W-2 -: EXP_W];
        eb     = b_q[W-2 -: EXP_W];
        ma     = a_q[MAN_W-1:0];
        mb     = b_q[MAN_W-1:0];
        sign   = sa ^ sb;
        a_nan  = (&ea) & (|ma);
        b_nan  = (&eb) & (|mb);
        a_inf  = (&ea) & ~(|ma);
        b_inf  = (&eb) & ~(|mb);
        a_zero = (ea == '0);
        b_zero = (eb == '0);

        e_raw   = EW'(ea) + EW'(eb) - EW'(BIAS);
        // Product in [1,4): a set MSB means the binary point moves one place left.
        shifted = prod_q[PW-1] ? (prod_q >> 1) : prod_q;
        lost    = prod_q[PW-1] & prod_q[0];
        e_norm  = e_raw + EW'(prod_q[PW-1]);

        man_t  = shifted[2*MAN_W-1 -: MAN_W];
        guard  = shifted[MAN_W-1];
        sticky = (|shifted[MAN_W-2:0]) | lost;
        rnd_up = guard & (sticky | man_t[0]);
        man_r  = {1'b0, man_t} + (MAN_W + 1)'(rnd_up);
        man_f  = man_r[MAN_W-1:0];
        e_fin  = e_norm + EW'(man_r[MAN_W]);

        e_low  = e_fin[EW-1] | (e_fin == '0);
        e_high = ~e_low & (e_fin >= EW'(MAXE));

        norm_res = {sign, e_fin[EXP_W-1:0], man_f};
        norm_exc = 3'b000;
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
            norm_res = QNAN;
            norm_exc = 3'b001;
        end else if (a_inf | b_inf) begin
            norm_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero | b_zero) begin
            norm_res = {sign, {(W - 1){1'b0}}};
        end else if (e_high) begin
            norm_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            norm_exc = 3'b100;
        end else if (e_low) begin
            norm_res = {sign, {(W - 1){1'b0}}};
            norm_exc = 3'b010;
        end
    end

    assign unused_bits = ^shifted[PW-1:PW-2];

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        result_d    = result_q;
        exc_d       = exc_q;

        unique case (state_q)
            StIdle: begin
                if (bus_io.in_valid) begin
                    a_d        = bus_io.op_a;
                    b_d        = bus_io.op_b;
                    mcand_d    = PW'({1'b1, bus_io.op_a[MAN_W-1:0]});
                    mplier_d   = {1'b1, bus_io.op_b[MAN_W-1:0]};
                    prod_d     = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = StMul;
                end
            end
            StMul: begin
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(MAN_W)) begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                result_d    = norm_res;
                exc_d       = norm_exc;
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (bus_io.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
            exc_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            result_q    <= result_d;
            exc_q       <= exc_d;
        end
    end

    assign bus_io.in_ready  = in_ready_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.busy      = busy_q;
    assign bus_io.result    = result_q;
    assign bus_io.exc       = exc_q;
endmodule

// File: tb/tb_fpp_fmul_seq.sv
// Directed bench for fpp_fmul_seq: scoreboard of expected products, checked when results appear.
module tb_fpp_fmul_seq;
    localparam int unsigned EXP_W = 5;
    localparam int unsigned MAN_W = 10;
    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int          LAT   = MAN_W + 2;

    typedef struct packed {
        logic [W-1:0] res;
        logic [2:0]   exc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpp_fmul_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fpp_fmul_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [W-1:0] res, input logic [2:0] exc);
        exp_t e;
        e.res = res;
        e.exc = exc;
        sb.push_back(e);
    endtask

    // Presents one operand pair and returns just after the accept edge.
    task automatic accept(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, bus.busy, 1);
    endtask

    task automatic wait_out(input string tag);
        int lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.out_valid && lat < 40);
        check({tag, "_latency"}, lat, LAT);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, bus.result, e.res);
            check({tag, "_exc"}, bus.exc, e.exc);
        end
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_drained"}, bus.out_valid, 0);
        check({tag, "_ready_after"}, bus.in_ready, 1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input logic [2:0] exc);
        push(res, exc);
        accept(tag, a, b);
        wait_out(tag);
        compare(tag);
        drain(tag);
    endtask

    logic [W-1:0] held;
    logic         seen;
    logic [W-1:0] bb_a[4]   = '{16'h4000, 16'h3C01, 16'hC6B6, 16'h7BFF};
    logic [W-1:0] bb_b[4]   = '{16'h4200, 16'h3E00, 16'h3C00, 16'h7BFF};
    logic [W-1:0] bb_r[4]   = '{16'h4600, 16'h3E02, 16'hC6B6, 16'h7C00};
    logic [2:0]   bb_e[4]   = '{3'b000, 3'b000, 3'b000, 3'b100};

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_exc", bus.exc, 0);
        check("rst_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("two_x_three", 16'h4000, 16'h4200, 16'h4600, 3'b000);
        run_op("neg_x_one", 16'hC6B6, 16'h3C00, 16'hC6B6, 3'b000);
        run_op("sticky_no_rnd", 16'h3C01, 16'h3C01, 16'h3C02, 3'b000);
        run_op("tie_even", 16'h3C01, 16'h3E00, 16'h3E02, 3'b000);
        run_op("overflow", 16'h7BFF, 16'h7BFF, 16'h7C00, 3'b100);
        run_op("underflow", 16'h0400, 16'h0400, 16'h0000, 3'b010);
        run_op("inf_x_zero", 16'h7C00, 16'h0000, 16'h7E00, 3'b001);
        run_op("nan_in", 16'h7C01, 16'h3C00, 16'h7E00, 3'b001);
        run_op("neg_inf", 16'hFC00, 16'h4000, 16'hFC00, 3'b000);
        run_op("zero_x_neg", 16'h0000, 16'hC000, 16'h8000, 3'b000);

        // Stall in DONE with stray in_valid pulses.
        push(16'h4600, 3'b000);
        accept("stall", 16'h4000, 16'h4200);
        wait_out("stall");
        held = bus.result;
        compare("stall");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = (i % 2 == 0);
            bus.op_a     = 16'h3C00;
            bus.op_b     = 16'h3C00;
            @(posedge clk);
            #1;
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_result", bus.result, held);
            check("stall_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        drain("stall");
        @(posedge clk);
        #1;
        check("stall_no_accept", bus.busy, 0);

        // Reset during the fourth MUL cycle discards the operation.
        accept("midrst", 16'h4000, 16'h4000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_busy", bus.busy, 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            seen = seen | bus.out_valid;
        end
        check("midrst_no_pulse", seen, 0);
        run_op("after_rst", 16'h4000, 16'h4000, 16'h4400, 3'b000);

        // Back-to-back with both handshakes held high.
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op_a      = bb_a[0];
        bus.op_b      = bb_b[0];
        push(bb_r[0], bb_e[0]);
        @(posedge clk);
        #1;
        check("b2b_first_busy", bus.busy, 1);
        for (int k = 0; k < 4; k++) begin
            wait_out("b2b");
            compare("b2b");
            if (k < 3) begin
                bus.op_a = bb_a[k+1];
                bus.op_b = bb_b[k+1];
                push(bb_r[k+1], bb_e[k+1]);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check("b2b_drained", bus.out_valid, 0);
            check("b2b_ready", bus.in_ready, 1);
            if (k < 3) begin
                @(posedge clk);
                #1;
                check("b2b_accepted", bus.in_ready, 0);
                check("b2b_busy", bus.busy, 1);
            end
        end
        bus.out_ready = 1'b0;
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
